// File: rtl/pid_pwm_driver.sv
// rtl/pid_pwm_driver.sv - PID control word to PWM + direction H-bridge driver with dead time
module pid_pwm_driver #(
    parameter int CNT_W    = 10,
    parameter int PERIOD   = 1000,
    parameter int SHIFT    = 4,
    parameter int DEADTIME = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_un,
    input  logic             i_valid,
    input  logic             i_enable,
    output logic             o_pwm,
    output logic             o_dir,
    output logic             o_sat,
    output logic [CNT_W-1:0] o_duty,
    output logic             o_period_start
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(PERIOD);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   pend_duty, act_duty, cap_duty, ld_duty, duty_n;
    logic               pend_dir, act_dir, cap_dir, ld_dir, dir_n;
    logic               pend_sat, act_sat, cap_sat, ld_sat, sat_n;
    logic               load, pwm_q, pwm_n, ps_q, ps_n;
    logic signed [32:0] shifted;
    logic [32:0]        mag;

    // 33-bit sign extension keeps |-2^31 >>> SHIFT| representable
    always_comb begin
        shifted  = $signed({i_un[31], i_un}) >>> SHIFT;
        mag      = shifted[32] ? 33'(-shifted) : 33'(shifted);
        cap_dir  = shifted[32];
        cap_sat  = (mag > 33'(PERIOD));
        cap_duty = cap_sat ? PER_MAX : mag[CNT_W-1:0];
        // a capture on the load cycle bypasses the stale pending value
        ld_duty  = i_valid ? cap_duty : pend_duty;
        ld_dir   = i_valid ? cap_dir  : pend_dir;
        ld_sat   = i_valid ? cap_sat  : pend_sat;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = (ld_dir != act_dir) ? DEAD : RUN;
                end
            end
            RUN, DEAD: begin
                if (cnt == CNT_LAST) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = (ld_dir != act_dir) ? DEAD : RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (state == DEAD && cnt == DT_LAST) state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!i_enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            load    = 1'b0;
        end
        duty_n = load ? ld_duty : act_duty;
        dir_n  = load ? ld_dir  : act_dir;
        sat_n  = load ? ld_sat  : act_sat;
        // registered outputs are computed from next-cycle counter so they line up with cnt
        pwm_n  = (state_n == RUN) && (cnt_n < duty_n);
        ps_n   = (state_n != IDLE) && (cnt_n == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_duty <= '0;
            pend_dir  <= 1'b0;
            pend_sat  <= 1'b0;
            act_duty  <= '0;
            act_dir   <= 1'b0;
            act_sat   <= 1'b0;
            pwm_q     <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            if (i_valid) begin
                pend_duty <= cap_duty;
                pend_dir  <= cap_dir;
                pend_sat  <= cap_sat;
            end
            state    <= state_n;
            cnt      <= cnt_n;
            act_duty <= duty_n;
            act_dir  <= dir_n;
            act_sat  <= sat_n;
            pwm_q    <= pwm_n;
            ps_q     <= ps_n;
        end
    end

    assign o_pwm          = pwm_q;
    assign o_dir          = act_dir;
    assign o_sat          = act_sat;
    assign o_duty         = act_duty;
    assign o_period_start = ps_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// tb/tb_pid_pwm_driver.sv - directed self-checking bench for pid_pwm_driver
module tb_pid_pwm_driver;

    localparam int P = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] un = '0;
    logic        valid = 1'b0;
    logic        enable = 1'b0;
    logic        pwm, dir, sat, period_start;
    logic [9:0]  duty;

    int total = 0;
    int bad = 0;

    pid_pwm_driver #(.CNT_W(10), .PERIOD(P), .SHIFT(4), .DEADTIME(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_un(un), .i_valid(valid), .i_enable(enable),
        .o_pwm(pwm), .o_dir(dir), .o_sat(sat), .o_duty(duty), .o_period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [31:0] value);
        un = value;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // observe one full period starting at cnt=0; leaves the bench at cnt=0 of the next
    task automatic measure(input string tag, input int exp_high, input int exp_first, input int exp_last);
        int high = 0, first = -1, last = -1, ps_bad = 0;
        for (int i = 0; i < P; i++) begin
            if (pwm) begin
                high++;
                if (first < 0) first = i;
                last = i;
            end
            if (period_start !== (i == 0)) ps_bad++;
            tick();
        end
        check({tag, "_high"}, high, exp_high);
        check({tag, "_first"}, first, exp_first);
        check({tag, "_last"}, last, exp_last);
        check({tag, "_pstart"}, ps_bad, 0);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        tick();
        check("rst_pwm", pwm, 0);
        check("rst_dir", dir, 0);
        check("rst_sat", sat, 0);
        check("rst_duty", duty, 0);
        check("rst_pstart", period_start, 0);

        // 1: 3200 >>> 4 = 200 forward
        pulse(32'd3200);
        enable = 1'b1;
        tick();
        check("t1_duty", duty, 200);
        check("t1_dir", dir, 0);
        check("t1_sat", sat, 0);
        measure("t1", 200, 0, 199);

        // 2: -1600 >>> 4 = -100, reversal costs 8 dead cycles
        pulse(-32'sd1600);
        tick(P - 1);
        check("t2_dir", dir, 1);
        check("t2_duty", duty, 100);
        measure("t2_dead", 92, 8, 99);
        measure("t2_run", 100, 0, 99);

        // 3: saturation both ways
        pulse(32'h7FFF_FFFF);
        tick(P - 1);
        check("t3p_duty", duty, 1000);
        check("t3p_sat", sat, 1);
        check("t3p_dir", dir, 0);
        measure("t3p_dead", 992, 8, 999);
        measure("t3p_run", 1000, 0, 999);
        pulse(32'h8000_0000);
        tick(P - 1);
        check("t3n_duty", duty, 1000);
        check("t3n_sat", sat, 1);
        check("t3n_dir", dir, 1);
        measure("t3n_dead", 992, 8, 999);

        // 4: last valid in a period wins; valid on cnt=999 bypasses pending
        pulse(32'd800);
        pulse(32'd1600);
        tick(P - 2);
        check("t4_duty", duty, 100);
        check("t4_sat", sat, 0);
        measure("t4_last", 92, 8, 99);
        tick(P - 1);
        pulse(32'd3200);
        check("t4_bypass_duty", duty, 200);
        measure("t4_bypass", 200, 0, 199);

        // 5: disable mid-period, reload on re-enable
        tick(500);
        enable = 1'b0;
        tick();
        check("t5_pwm", pwm, 0);
        check("t5_pstart", period_start, 0);
        pulse(-32'sd3200);
        tick(3);
        check("t5_idle_pstart", period_start, 0);
        check("t5_idle_duty", duty, 200);
        check("t5_idle_dir", dir, 0);
        enable = 1'b1;
        tick();
        check("t5_re_dir", dir, 1);
        measure("t5_re", 192, 8, 199);

        // 6: reset while pwm is high
        tick(50);
        check("t6_pre_pwm", pwm, 1);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check("t6_pwm", pwm, 0);
        check("t6_dir", dir, 0);
        check("t6_sat", sat, 0);
        check("t6_duty", duty, 0);
        check("t6_pstart", period_start, 0);
        rst = 1'b0;
        tick(3);
        check("t6_idle_pstart", period_start, 0);
        enable = 1'b1;
        tick();
        check("t6_re_duty", duty, 0);
        measure("t6_re", 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
